// File: rtl/led_flash_ctrl.sv
// 8-LED flash sequencer. A prescaler produces a single-clock step enable, and the LED
// pattern runs through one of four modes for PASSES passes before done pulses.
module led_flash_ctrl #(
    parameter int N      = 6000000,
    parameter int WIDTH  = 24,
    parameter int PASSES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    output logic [7:0] led,
    output logic       busy,
    output logic       done,
    output logic       step
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(N - 1);
    localparam logic [3:0]       PASS_LAST = 4'(PASSES - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [3:0]       pos, pos_nx;
    logic [3:0]       pass, pass_nx;
    logic [1:0]       mode_q, mode_nx;
    logic [7:0]       led_nx;
    logic             busy_nx, done_nx, at_last;

    function automatic logic [7:0] init_pat(input logic [1:0] m);
        case (m)
            2'b01:   return 8'h80;
            2'b10:   return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [3:0] last_pos(input logic [1:0] m);
        case (m)
            2'b10:   return 4'd1;
            2'b11:   return 4'd13;
            default: return 4'd7;
        endcase
    endfunction

    // Ping-pong climbs for positions 0..6 and descends afterwards, so 8'h80 and
    // 8'h01 each appear once per pass.
    function automatic logic [7:0] next_pat(input logic [1:0] m, input logic [7:0] p,
                                            input logic [3:0] ps);
        case (m)
            2'b00:   return {p[6:0], p[7]};
            2'b01:   return {p[0], p[7:1]};
            2'b10:   return ~p;
            default: return (ps < 4'd7) ? (p << 1) : (p >> 1);
        endcase
    endfunction

    assign at_last = (state == S_RUN) && (cnt == CNT_LAST);
    assign step    = at_last && !stop;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pos_nx   = pos;
        pass_nx  = pass;
        mode_nx  = mode_q;
        led_nx   = led;
        case (state)
            S_IDLE: begin
                led_nx = 8'h00;
                cnt_nx = '0;
                if (start && !stop) begin
                    state_nx = S_LOAD;
                    mode_nx  = mode;
                end
            end
            S_LOAD: begin
                state_nx = S_RUN;
                led_nx   = init_pat(mode_q);
                cnt_nx   = '0;
                pos_nx   = '0;
                pass_nx  = '0;
            end
            S_RUN: begin
                cnt_nx = at_last ? '0 : cnt + WIDTH'(1);
                if (at_last) begin
                    if (pos == last_pos(mode_q)) begin
                        if (pass == PASS_LAST) begin
                            state_nx = S_DONE;
                            led_nx   = 8'h00;
                        end else begin
                            pass_nx = pass + 4'd1;
                            pos_nx  = '0;
                            led_nx  = init_pat(mode_q);
                        end
                    end else begin
                        pos_nx = pos + 4'd1;
                        led_nx = next_pat(mode_q, led, pos);
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                led_nx   = 8'h00;
            end
        endcase
        // Abort overrides everything outside IDLE.
        if (stop && state != S_IDLE) begin
            state_nx = S_IDLE;
            led_nx   = 8'h00;
            cnt_nx   = '0;
        end
        busy_nx = (state_nx == S_LOAD) || (state_nx == S_RUN);
        done_nx = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            pos    <= '0;
            pass   <= '0;
            mode_q <= 2'b00;
            led    <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pos    <= pos_nx;
            pass   <= pass_nx;
            mode_q <= mode_nx;
            led    <= led_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_led_flash_ctrl.sv
// Directed bench for led_flash_ctrl: three instances with different N/PASSES
// share the inputs; sel picks which one's outputs are checked.
module tb_led_flash_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [1:0] mode;
    logic [7:0] led_a, led_b, led_c, led_o;
    logic       busy_a, busy_b, busy_c, busy_o;
    logic       done_a, done_b, done_c, done_o;
    logic       step_a, step_b, step_c, step_o;
    int         sel;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    led_flash_ctrl #(.N(4), .WIDTH(24), .PASSES(2)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .led(led_a), .busy(busy_a), .done(done_a), .step(step_a));
    led_flash_ctrl #(.N(2), .WIDTH(24), .PASSES(1)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .led(led_b), .busy(busy_b), .done(done_b), .step(step_b));
    led_flash_ctrl #(.N(3), .WIDTH(24), .PASSES(2)) u_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .led(led_c), .busy(busy_c), .done(done_c), .step(step_c));

    always_comb begin
        case (sel)
            1:       begin led_o = led_b; busy_o = busy_b; done_o = done_b; step_o = step_b; end
            2:       begin led_o = led_c; busy_o = busy_c; done_o = done_c; step_o = step_c; end
            default: begin led_o = led_a; busy_o = busy_a; done_o = done_a; step_o = step_a; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pat_len(input logic [1:0] m);
        case (m)
            2'b10:   return 2;
            2'b11:   return 14;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] exp_pat(input logic [1:0] m, input int p);
        logic [7:0] one;
        one = 8'h01;
        case (m)
            2'b00:   return one << p;
            2'b01:   return 8'h80 >> p;
            2'b10:   return (p % 2 == 0) ? 8'hFF : 8'h00;
            default: return (p <= 7) ? (one << p) : (one << (14 - p));
        endcase
    endfunction

    task automatic idle_all();
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
    endtask

    // One full run from IDLE through DONE. noisy keeps start high and scrambles mode.
    task automatic run_check(input string tag, input int s, input logic [1:0] m,
                             input int n, input int passes, input bit noisy);
        int total, steps, p;
        sel   = s;
        mode  = m;
        start = 1'b1;
        tick();
        chk({tag, "_load_busy"}, busy_o, 1);
        chk({tag, "_load_led"}, led_o, 8'h00);
        if (!noisy) start = 1'b0;
        tick();
        total = n * pat_len(m) * passes;
        steps = 0;
        for (int c = 0; c < total; c++) begin
            p = (c / n) % pat_len(m);
            if (noisy) mode = 2'(c);
            #1;
            chk($sformatf("%s_led_c%0d", tag, c), led_o, exp_pat(m, p));
            chk($sformatf("%s_step_c%0d", tag, c), step_o, (c % n == n - 1) ? 1 : 0);
            chk($sformatf("%s_busy_c%0d", tag, c), busy_o, 1);
            chk($sformatf("%s_done_c%0d", tag, c), done_o, 0);
            if (step_o) steps++;
            tick();
        end
        chk({tag, "_done_pulse"}, done_o, 1);
        chk({tag, "_done_led"}, led_o, 8'h00);
        chk({tag, "_done_busy"}, busy_o, 0);
        chk({tag, "_done_step"}, step_o, 0);
        chk({tag, "_step_count"}, steps, pat_len(m) * passes);
        tick();
        chk({tag, "_idle_done"}, done_o, 0);
        chk({tag, "_idle_busy"}, busy_o, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; sel = 0;
        tick(); tick();
        chk("rst_led", led_o, 8'h00);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_step", step_o, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy_o, 0);

        // mode 00, N=4, PASSES=2: 16 patterns, done 64 clocks after entering RUN
        run_check("rotl", 0, 2'b00, 4, 2, 1'b0);

        // stop at the 5th pattern, in the cycle where step would fire
        idle_all();
        sel = 0; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (19) tick();
        chk("stop_pre_led", led_o, 8'h10);
        chk("stop_pre_step", step_o, 1);
        stop = 1'b1; start = 1'b1;
        #1;
        chk("stop_step_suppressed", step_o, 0);
        tick();
        chk("stop_led", led_o, 8'h00);
        chk("stop_busy", busy_o, 0);
        chk("stop_done", done_o, 0);
        tick();
        chk("stop_start_busy", busy_o, 0);
        stop = 1'b0; start = 1'b0;
        tick();
        chk("stop_after_busy", busy_o, 0);
        chk("stop_after_done", done_o, 0);

        // asynchronous reset in the middle of a run
        idle_all();
        sel = 0; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (10) tick();
        chk("arst_pre_led", led_o, 8'h04);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", led_o, 8'h00);
        chk("arst_busy", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("arst_quiet_busy%0d", i), busy_o, 0);
            chk($sformatf("arst_quiet_led%0d", i), led_o, 8'h00);
        end

        // mode 01 with start held and mode toggling; restart right after DONE->IDLE
        run_check("rotr_noisy", 0, 2'b01, 4, 2, 1'b1);
        tick();
        chk("held_start_relaunch", busy_o, 1);
        idle_all();

        // N=2, PASSES=1 boundaries
        idle_all();
        run_check("pingpong", 1, 2'b11, 2, 1, 1'b0);
        idle_all();
        run_check("blink_p1", 1, 2'b10, 2, 1, 1'b0);
        // mode 10, N=3, PASSES=2: FF,00,FF,00
        idle_all();
        run_check("blink_n3", 2, 2'b10, 3, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
